// File: rtl/enemy_controller.sv
// rtl/enemy_controller.sv - per-enemy behaviour engine feeding the sprite draw stage
// Updates position, facing, mode, animation phase and health once per processed frame tick.
module enemy_controller #(
  parameter logic [7:0] X_MIN       = 8'd16,
  parameter logic [7:0] X_MAX       = 8'd224,
  parameter logic [7:0] X_START     = 8'd120,
  parameter logic [7:0] Y_START     = 8'd200,
  parameter logic [5:0] IDLE_FRAMES = 6'd60,
  parameter logic [2:0] ANIM_DIV    = 3'd4,
  parameter logic [7:0] ATK_RANGE   = 8'd12,
  parameter logic [5:0] ATK_COOL    = 6'd30,
  parameter logic [2:0] HP_INIT     = 3'd3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [7:0] player_x,
  input  logic [7:0] player_y,
  input  logic       hit,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [1:0] behavior,
  output logic       isLeft,
  output logic [1:0] period,
  output logic [2:0] alive,
  output logic       dead
);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_ATTACK, S_DEAD} state_t;

  state_t     state, state_n;
  logic [5:0] frame_cnt, frame_cnt_n;
  logic [2:0] anim_cnt, anim_cnt_n;
  logic [5:0] cool_cnt, cool_cnt_n;
  logic       hit_pend, hit_pend_n;
  logic [7:0] x_n;
  logic       left_n;
  logic [1:0] period_n;
  logic [2:0] alive_n, alive_dec;
  logic [1:0] behavior_n;
  logic       proc_tick, hit_now, do_walk, in_range, anim_wrap;
  logic [8:0] dx, dy;

  always_comb begin
    proc_tick  = frame_tick & enable;
    hit_now    = hit_pend | hit;
    dx         = (player_x >= x) ? ({1'b0, player_x} - {1'b0, x}) : ({1'b0, x} - {1'b0, player_x});
    dy         = (player_y >= y) ? ({1'b0, player_y} - {1'b0, y}) : ({1'b0, y} - {1'b0, player_y});
    in_range   = (dx <= {1'b0, ATK_RANGE}) && (dy <= 9'd8);
    anim_wrap  = (anim_cnt == ANIM_DIV - 3'd1);
    alive_dec  = (hit_now && alive != 3'd0) ? alive - 3'd1 : alive;

    state_n     = state;
    frame_cnt_n = frame_cnt;
    anim_cnt_n  = anim_cnt;
    cool_cnt_n  = cool_cnt;
    hit_pend_n  = hit_pend | hit;
    x_n         = x;
    left_n      = isLeft;
    period_n    = period;
    alive_n     = alive;
    do_walk     = 1'b0;

    if (proc_tick) begin
      hit_pend_n = 1'b0;
      if (state != S_DEAD) begin
        if (alive_dec == 3'd0) begin
          // Killing blow pre-empts every other update this tick.
          state_n    = S_DEAD;
          alive_n    = 3'd0;
          anim_cnt_n = 3'd0;
          period_n   = 2'd0;
        end else begin
          alive_n    = alive_dec;
          anim_cnt_n = anim_wrap ? 3'd0 : anim_cnt + 3'd1;
          period_n   = anim_wrap ? period + 2'd1 : period;
          if (cool_cnt != 6'd0) cool_cnt_n = cool_cnt - 6'd1;
          case (state)
            S_IDLE: begin
              if (frame_cnt < IDLE_FRAMES) frame_cnt_n = frame_cnt + 6'd1;
              else do_walk = 1'b1;
            end
            S_WALK: do_walk = 1'b1;
            S_ATTACK: begin
              if (anim_wrap && period == 2'd3) begin
                state_n    = S_WALK;
                cool_cnt_n = ATK_COOL;
              end
            end
            default: ;
          endcase
          // The tick that ends IDLE is already the first walking tick.
          if (do_walk) begin
            state_n = S_WALK;
            if (cool_cnt == 6'd0 && in_range) begin
              state_n = S_ATTACK;
              left_n  = (player_x < x);
            end else if (isLeft && x <= X_MIN) begin
              left_n = 1'b0;
            end else if (!isLeft && x >= X_MAX) begin
              left_n = 1'b1;
            end else if (isLeft) begin
              x_n = x - 8'd1;
            end else begin
              x_n = x + 8'd1;
            end
          end
          if (state_n != state) begin
            anim_cnt_n = 3'd0;
            period_n   = 2'd0;
          end
        end
      end
    end

    case (state_n)
      S_WALK:   behavior_n = 2'd1;
      S_ATTACK: behavior_n = 2'd2;
      default:  behavior_n = 2'd0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      frame_cnt <= 6'd0;
      anim_cnt  <= 3'd0;
      cool_cnt  <= 6'd0;
      hit_pend  <= 1'b0;
      x         <= X_START;
      y         <= Y_START;
      behavior  <= 2'd0;
      isLeft    <= 1'b0;
      period    <= 2'd0;
      alive     <= HP_INIT;
      dead      <= 1'b0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_cnt_n;
      anim_cnt  <= anim_cnt_n;
      cool_cnt  <= cool_cnt_n;
      hit_pend  <= hit_pend_n;
      x         <= x_n;
      y         <= Y_START;
      behavior  <= behavior_n;
      isLeft    <= left_n;
      period    <= period_n;
      alive     <= alive_n;
      dead      <= (state_n == S_DEAD);
    end
  end

endmodule

// File: tb/tb_enemy_controller.sv
// tb/tb_enemy_controller.sv - self-checking bench for enemy_controller
// Frame-level behavioural model compared every cycle, plus directed literal checks.
module tb_enemy_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b0;
  logic       hit = 1'b0;
  logic [7:0] player_x = 8'd0;
  logic [7:0] player_y = 8'd0;
  logic [7:0] x, y;
  logic [1:0] behavior, period;
  logic       isLeft, dead;
  logic [2:0] alive;

  always #5 Clk = ~Clk;

  enemy_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .enable(enable),
    .player_x(player_x), .player_y(player_y), .hit(hit),
    .x(x), .y(y), .behavior(behavior), .isLeft(isLeft),
    .period(period), .alive(alive), .dead(dead)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 walk, 2 attack, 3 dead; m_t counts ticks since mode entry.
  int m_x, m_left, m_mode, m_idle, m_atk, m_cool, m_t, m_alive, m_pend;

  task automatic m_reset();
    m_x = 120; m_left = 0; m_mode = 0; m_idle = 0; m_atk = 0;
    m_cool = 0; m_t = 0; m_alive = 3; m_pend = 0;
  endtask

  task automatic m_tick();
    int hn, cb, dx, dy;
    hn = (m_pend != 0 || hit) ? 1 : 0;
    m_pend = 0;
    if (m_mode == 3) return;
    if (hn != 0 && m_alive <= 1) begin
      m_alive = 0; m_mode = 3; m_t = 0;
      return;
    end
    if (hn != 0) m_alive = m_alive - 1;
    cb = m_cool;
    if (m_cool > 0) m_cool = m_cool - 1;
    m_t = m_t + 1;
    if (m_mode == 2) begin
      m_atk = m_atk + 1;
      if (m_atk == 16) begin m_mode = 1; m_cool = 30; m_t = 0; end
    end else if (m_mode == 0 && m_idle < 60) begin
      m_idle = m_idle + 1;
    end else begin
      dx = int'(player_x) - m_x; if (dx < 0) dx = -dx;
      dy = int'(player_y) - 200; if (dy < 0) dy = -dy;
      if (cb == 0 && dx <= 12 && dy <= 8) begin
        m_mode = 2; m_left = (int'(player_x) < m_x) ? 1 : 0; m_atk = 0; m_t = 0;
      end else begin
        if (m_mode == 0) begin m_mode = 1; m_t = 0; end
        if (m_left != 0 && m_x <= 16) m_left = 0;
        else if (m_left == 0 && m_x >= 224) m_left = 1;
        else m_x = m_x + ((m_left != 0) ? -1 : 1);
      end
    end
  endtask

  always @(posedge Clk or posedge Reset) begin
    if (Reset) m_reset();
    else if (frame_tick && enable) m_tick();
    else if (hit) m_pend = 1;
  end

  always @(negedge Clk) begin
    chk("model_x", int'(x), m_x);
    chk("model_y", int'(y), 200);
    chk("model_behavior", int'(behavior), (m_mode == 3) ? 0 : m_mode);
    chk("model_isLeft", int'(isLeft), m_left);
    chk("model_period", int'(period), (m_mode == 3) ? 0 : (m_t / 4) % 4);
    chk("model_alive", int'(alive), m_alive);
    chk("model_dead", int'(dead), (m_mode == 3) ? 1 : 0);
  end

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    @(negedge Clk);
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    @(negedge Clk);
    hit = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, int'(x), 120);
    chk({tag, "_y"}, int'(y), 200);
    chk({tag, "_behavior"}, int'(behavior), 0);
    chk({tag, "_isLeft"}, int'(isLeft), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_alive"}, int'(alive), 3);
    chk({tag, "_dead"}, int'(dead), 0);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk_reset_vals("reset");
    Reset = 1'b0;
    enable = 1'b1;

    for (int i = 0; i < 60; i++) begin
      tick();
      chk("idle_behavior", int'(behavior), 0);
    end
    tick();
    chk("walk_start_behavior", int'(behavior), 1);
    chk("walk_start_x", int'(x), 121);

    repeat (102) tick();
    chk("walk_reach_x", int'(x), 223);
    tick();
    chk("edge_x224", int'(x), 224);
    chk("edge_left0", int'(isLeft), 0);
    tick();
    chk("turn_left1", int'(isLeft), 1);
    chk("turn_x_held", int'(x), 224);
    tick();
    chk("back_x223", int'(x), 223);

    player_x = 8'd233;
    player_y = 8'd200;
    tick();
    chk("atk_behavior", int'(behavior), 2);
    chk("atk_isLeft", int'(isLeft), 0);
    chk("atk_x", int'(x), 223);
    chk("atk_period0", int'(period), 0);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("atk_period", int'(period), k / 4);
      chk("atk_hold", int'(behavior), 2);
    end
    tick();
    chk("atk_done", int'(behavior), 1);

    for (int i = 0; i < 30; i++) begin
      player_x = 8'(m_x);
      tick();
      chk("cooldown_walk", int'(behavior), 1);
    end
    player_x = 8'(m_x);
    tick();
    chk("reattack", int'(behavior), 2);
    player_y = 8'd0;
    repeat (16) tick();
    chk("reattack_done", int'(behavior), 1);

    pulse_hit(); pulse_hit(); pulse_hit();
    chk("hit_before_tick", int'(alive), 3);
    tick();
    chk("multi_hit_once", int'(alive), 2);
    hit = 1'b1; frame_tick = 1'b1;
    @(negedge Clk);
    hit = 1'b0; frame_tick = 1'b0;
    @(negedge Clk);
    chk("coincident_hit", int'(alive), 1);
    tick();
    chk("hit_not_recounted", int'(alive), 1);

    enable = 1'b0;
    pulse_hit();
    tick();
    chk("disabled_alive", int'(alive), 1);
    enable = 1'b1;
    tick();
    chk("kill_alive", int'(alive), 0);
    chk("kill_dead", int'(dead), 1);
    chk("kill_behavior", int'(behavior), 0);
    pulse_hit();
    tick(); tick();
    chk("dead_alive", int'(alive), 0);
    chk("dead_flag", int'(dead), 1);
    chk("dead_period", int'(period), 0);

    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    player_x = 8'd0;
    player_y = 8'd0;
    repeat (61) tick();
    chk("rewalk_x", int'(x), 121);
    player_x = 8'd131;
    player_y = 8'd200;
    tick();
    chk("reattack2", int'(behavior), 2);
    repeat (5) tick();
    #2 Reset = 1'b1;
    #1 chk_reset_vals("async_reset");
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
